layer_compositor: RTL and testbench
===================================

Name: layer_compositor

Overview:
- Parametrised successor to the fixed grey/white/background colour select in the VGA top level.
- Merges NUM_LAYERS sprite hit/colour channels into one RGB332 pixel with fixed index priority; priority and timing are registered.
- Adds display modes (normal, night-invert, game-over flash) and per-frame collision detection between the player layer and the obstacle layers.
- Sits between the sprite delegates / VGA scan generator and the vgaRed/vgaGreen/vgaBlue, Hsync and Vsync pins.

Parameters:
- NUM_LAYERS, 8: number of sprite layers; index 0 has the highest priority and is the player layer.
- SCREEN_W, 640: visible width in pixels.
- SCREEN_H, 480: visible height in pixels.
- FLASH_FRAMES, 15: frames per half-period of the game-over flash.
- COLLIDE_MASK, {NUM_LAYERS{1'b1}} & ~1: layers that count as obstacles for collision.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- pix_en  in  1  pixel strobe (25 MHz enable); all pipeline state advances only when high.
- x  in  10  scan X.
- y  in  10  scan Y.
- hsync_in  in  1  raw Hsync, active-low.
- vsync_in  in  1  raw Vsync, active-low.
- layer_hit  in  NUM_LAYERS  per-layer pixel hit.
- layer_color  in  8*NUM_LAYERS  per-layer RGB332; layer i occupies bits [8i+7:8i].
- bg_color  in  8  background RGB332.
- mode  in  2  display mode: 00 normal, 01 night, 10 game-over, 11 reserved (treated as normal).
- clear_collision  in  1  clears the sticky collision flag.
- vgaRed  out  3  red component.
- vgaGreen  out  3  green component.
- vgaBlue  out  2  blue component.
- Hsync  out  1  delayed Hsync.
- Vsync  out  1  delayed Vsync.
- win_layer  out  $clog2(NUM_LAYERS)  winning layer index; 0 when no layer wins.
- collision_pulse  out  1  one-clk pulse at end of a frame that contained a collision.
- collided  out  1  sticky collision flag.

Behaviour:
- Reset values:
  - colour outputs 0; Hsync=1; Vsync=1; win_layer 0.
  - collision_pulse 0; collided 0.
  - pipeline registers, flash counter and flash phase all 0.
- Pipeline, two stages, each advancing only on a clk edge with pix_en=1; with pix_en=0 every register holds.
  - S1 registers layer_hit, layer_color, bg_color, hsync_in, vsync_in, and visible = (x < SCREEN_W) && (y < SCREEN_H).
  - S2 computes the output:
    - lowest-index set hit wins; otherwise bg_color;
    - if not visible, colour is forced to 0;
    - then the mode transform is applied.
  - Latency is exactly 2 pix_en strobes from the inputs to colour/sync/win_layer. Syncs are delayed identically to the colour.
- Mode transform:
  - Night: output = ~colour (bitwise, all 8 bits); blanking stays 0.
  - Game-over: output is inverted when flash_phase=1, otherwise unchanged.
- Frame end is a falling edge of the S1-registered vsync, detected on a pix_en cycle.
- Flash timer:
  - While mode=10, the frame counter increments at each frame end.
  - When the count reaches FLASH_FRAMES-1, the counter returns to 0 and flash_phase toggles.
  - Any other mode holds the counter and phase at 0 synchronously; re-entry always starts with phase 0.
- Collision:
  - An S1 visible pixel with hit[0] && |(hit & COLLIDE_MASK) sets frame_hit.
  - At frame end: collision_pulse=1 for one clk if frame_hit (including a hit in the same cycle); frame_hit clears; collided is set.
  - clear_collision clears collided. If a set and a clear occur in the same cycle, the set wins.
  - Hits while not visible are ignored.
- A mode change mid-frame takes effect on the next S2 pixel; there is no frame alignment.
- rst asserted mid-frame immediately forces all outputs to their reset values. The first valid pixel appears 2 strobes after rst deasserts.

Decomposition:
- Package vga_pkg holds:
  - RGB332 field widths (R_W=3, G_W=3, B_W=2, COLOR_W=8);
  - mode encodings MODE_NORMAL, MODE_NIGHT, MODE_GAMEOVER;
  - SCREEN_W and SCREEN_H defaults.
- One sub-module, layer_priority_sel: a purely combinational, parametrised lowest-index priority encoder that returns a valid bit, the winning index and the winning colour. It is instantiated in S2.

Test Plan:
- NUM_LAYERS=8; hits on layers 2 and 5 with colours 0x1C and 0xE0; mode 00 → output 0x1C (R=0, G=7, B=0), win_layer=2, exactly 2 pix_en strobes later. Hsync/Vsync edges shift by the same 2 strobes.
- No hits, bg_color=0xFF, x=640 (not visible) → output 0x00; at x=639, y=479 → 0xFF. In mode 01 at x=639 → 0x00; at x=640 the output stays 0x00.
- Mode 10, FLASH_FRAMES=2, 6 frames of bg 0xFF → per-frame output sequence 0xFF, 0xFF, 0x00, 0x00, 0xFF, 0xFF. Switching to 00 mid-flash and back restarts at phase 0.
- Layers 0 and 3 both hit at (100,200) in one frame → collision_pulse high for one clk at the Vsync falling edge, collided=1. The next frame without overlap gives no pulse while collided stays 1. clear_collision → collided=0.
- Overlap of layers 0 and 3 only at x=700 (not visible) → no pulse. Overlap on the last visible pixel while clear_collision is held → pulse occurs and collided=1.
- Hold pix_en=0 for 10 clk mid-line → outputs frozen. Assert rst mid-frame → Hsync=Vsync=1, colour 0 and collided=0 immediately, asynchronously.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA pixel-path definitions: RGB332 layout, display modes, screen defaults.
package vga_pkg;
  localparam int R_W     = 3;
  localparam int G_W     = 3;
  localparam int B_W     = 2;
  localparam int COLOR_W = R_W + G_W + B_W;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;

  // 2'b11 is reserved and behaves as normal
  typedef enum logic [1:0] {
    MODE_NORMAL   = 2'b00,
    MODE_NIGHT    = 2'b01,
    MODE_GAMEOVER = 2'b10
  } mode_e;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb332_t;
endpackage

// File: rtl/layer_compositor_if.sv
// Scan/sprite side to compositor bundle; master = scan generator + sprites, slave = compositor.
interface layer_compositor_if import vga_pkg::*; #(
  parameter int NUM_LAYERS = 8
);
  localparam int WIN_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic                            pix_en;
  logic [9:0]                      x;
  logic [9:0]                      y;
  logic                            hsync_in;
  logic                            vsync_in;
  logic [NUM_LAYERS-1:0]           layer_hit;
  logic [COLOR_W*NUM_LAYERS-1:0]   layer_color;
  logic [COLOR_W-1:0]              bg_color;
  logic [1:0]                      mode;
  logic                            clear_collision;
  logic [R_W-1:0]                  vgaRed;
  logic [G_W-1:0]                  vgaGreen;
  logic [B_W-1:0]                  vgaBlue;
  logic                            Hsync;
  logic                            Vsync;
  logic [WIN_W-1:0]                win_layer;
  logic                            collision_pulse;
  logic                            collided;

  modport master (
    output pix_en, x, y, hsync_in, vsync_in, layer_hit, layer_color, bg_color,
           mode, clear_collision,
    input  vgaRed, vgaGreen, vgaBlue, Hsync, Vsync, win_layer, collision_pulse, collided
  );

  modport slave (
    input  pix_en, x, y, hsync_in, vsync_in, layer_hit, layer_color, bg_color,
           mode, clear_collision,
    output vgaRed, vgaGreen, vgaBlue, Hsync, Vsync, win_layer, collision_pulse, collided
  );
endinterface

// File: rtl/layer_priority_sel.sv
// Combinational lowest-index-wins selector over the sprite layers.
module layer_priority_sel import vga_pkg::*; #(
  parameter int NUM_LAYERS = 8,
  parameter int IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic [NUM_LAYERS-1:0]              hit,
  input  logic [NUM_LAYERS-1:0][COLOR_W-1:0] color,
  output logic                               valid,
  output logic [IDX_W-1:0]                   idx,
  output logic [COLOR_W-1:0]                 winColor
);
  // Scan high to low so the last (lowest) hit overrides
  always_comb begin
    valid    = 1'b0;
    idx      = '0;
    winColor = '0;
    for (int i = NUM_LAYERS-1; i >= 0; i--) begin
      if (hit[i]) begin
        valid    = 1'b1;
        idx      = IDX_W'(i);
        winColor = color[i];
      end
    end
  end
endmodule

// File: rtl/layer_compositor.sv
// Two-stage sprite compositor: S1 registers scan inputs, S2 resolves priority, blanking
// and display mode; also runs the game-over flash timer and per-frame collision detect.
module layer_compositor import vga_pkg::*; #(
  parameter int NUM_LAYERS   = 8,
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int SCREEN_H     = DEF_SCREEN_H,
  parameter int FLASH_FRAMES = 15,
  parameter logic [NUM_LAYERS-1:0] COLLIDE_MASK = {{(NUM_LAYERS-1){1'b1}}, 1'b0}
) (
  input logic               clk,
  input logic               rst,
  layer_compositor_if.slave bus
);
  localparam int WIN_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  logic [NUM_LAYERS-1:0]              s1Hit;
  logic [NUM_LAYERS-1:0][COLOR_W-1:0] s1Color;
  logic [COLOR_W-1:0]                 s1Bg;
  logic                               s1Hs, s1Vs, s1Vis, s1VsPrev;
  logic                               visIn;

  logic                               selValid;
  logic [WIN_W-1:0]                   selIdx;
  logic [COLOR_W-1:0]                 selColor, pixColor, outColor;
  logic                               invert;

  rgb332_t                            rgbQ;
  logic                               hsQ, vsQ;
  logic [WIN_W-1:0]                   winQ;

  logic [CNT_W-1:0]                   flashCnt;
  logic                               flashPhase;
  logic                               frameEnd, collideNow, frameHit, setCollide;
  logic                               pulseQ, collidedQ;

  assign visIn = (bus.x < 10'(SCREEN_W)) && (bus.y < 10'(SCREEN_H));

  // ---- S1: capture scan position and sprite channels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Hit    <= '0;
      s1Color  <= '0;
      s1Bg     <= '0;
      s1Hs     <= 1'b0;
      s1Vs     <= 1'b0;
      s1Vis    <= 1'b0;
      s1VsPrev <= 1'b0;
    end else if (bus.pix_en) begin
      s1Hit    <= bus.layer_hit;
      s1Color  <= bus.layer_color;
      s1Bg     <= bus.bg_color;
      s1Hs     <= bus.hsync_in;
      s1Vs     <= bus.vsync_in;
      s1Vis    <= visIn;
      s1VsPrev <= s1Vs;
    end
  end

  layer_priority_sel #(.NUM_LAYERS(NUM_LAYERS), .IDX_W(WIN_W)) uSel (
    .hit      (s1Hit),
    .color    (s1Color),
    .valid    (selValid),
    .idx      (selIdx),
    .winColor (selColor)
  );

  // Blanking is applied before the mode transform so inverted modes keep black borders
  always_comb begin
    pixColor = selValid ? selColor : s1Bg;
    invert   = (bus.mode == MODE_NIGHT) || ((bus.mode == MODE_GAMEOVER) && flashPhase);
    outColor = '0;
    if (s1Vis) outColor = invert ? ~pixColor : pixColor;
  end

  // ---- S2: output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgbQ <= '0;
      hsQ  <= 1'b1;
      vsQ  <= 1'b1;
      winQ <= '0;
    end else if (bus.pix_en) begin
      rgbQ <= rgb332_t'(outColor);
      hsQ  <= s1Hs;
      vsQ  <= s1Vs;
      winQ <= selIdx;
    end
  end

  // Falling edge of the S1 vsync coincides with the Vsync pin falling
  assign frameEnd   = bus.pix_en && s1VsPrev && !s1Vs;
  assign collideNow = bus.pix_en && s1Vis && s1Hit[0] && |(s1Hit & COLLIDE_MASK);
  assign setCollide = frameEnd && (frameHit || collideNow);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flashCnt   <= '0;
      flashPhase <= 1'b0;
    end else if (bus.mode != MODE_GAMEOVER) begin
      flashCnt   <= '0;
      flashPhase <= 1'b0;
    end else if (frameEnd) begin
      if (flashCnt == CNT_W'(FLASH_FRAMES-1)) begin
        flashCnt   <= '0;
        flashPhase <= ~flashPhase;
      end else begin
        flashCnt <= flashCnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frameHit  <= 1'b0;
      pulseQ    <= 1'b0;
      collidedQ <= 1'b0;
    end else begin
      pulseQ <= setCollide;
      if (frameEnd)        frameHit <= 1'b0;
      else if (collideNow) frameHit <= 1'b1;
      if (setCollide)               collidedQ <= 1'b1;
      else if (bus.clear_collision) collidedQ <= 1'b0;
    end
  end

  assign bus.vgaRed          = rgbQ.r;
  assign bus.vgaGreen        = rgbQ.g;
  assign bus.vgaBlue         = rgbQ.b;
  assign bus.Hsync           = hsQ;
  assign bus.Vsync           = vsQ;
  assign bus.win_layer       = winQ;
  assign bus.collision_pulse = pulseQ;
  assign bus.collided        = collidedQ;
endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: directed pixel/frame tables plus randomized scan checked
// against a frame-level reference model.
module tb_layer_compositor;
  import vga_pkg::*;
  localparam int NL = 8;
  localparam int FF = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  layer_compositor_if #(.NUM_LAYERS(NL)) bus();
  layer_compositor #(.NUM_LAYERS(NL), .FLASH_FRAMES(FF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [7:0]      hit;
    logic [7:0][7:0] col;
    logic [7:0]      bg;
    logic [9:0]      x;
    logic [9:0]      y;
    logic            hs;
    logic            vs;
  } pix_t;

  typedef struct {
    logic [7:0] hit; logic [7:0] bg; logic [9:0] x; logic [9:0] y; logic [1:0] mode;
    logic [7:0] expRgb; logic [2:0] expWin;
  } pvec_t;

  typedef struct {
    logic [7:0] hit; logic [7:0] bg; logic [1:0] mode; logic [9:0] x; logic [9:0] y;
    logic clr; logic [7:0] expMid; logic expPulse; logic expColl;
  } fvec_t;

  int nTests = 0;
  int nFail  = 0;

  logic [7:0][7:0] colTab;

  // Reference model state: pixel held in the first stage, previous vsync, frame
  // collision accumulator, sticky flag, frames elapsed in game-over mode.
  pix_t       mS1;
  logic       mVsPrev;
  bit         mAcc, mCol;
  int         mGo;
  logic [7:0] eRgb;
  logic [2:0] eWin;
  logic       eHs, eVs, ePulse, eCol;

  function automatic logic [7:0] refColor(pix_t p, logic [1:0] m, bit ph);
    logic [7:0] c;
    if (!(p.x < 640 && p.y < 480)) return 8'h00;
    c = p.bg;
    for (int i = 0; i < 8; i++) if (p.hit[i]) begin c = p.col[i]; break; end
    if (m == 2'b01 || (m == 2'b10 && ph)) c = ~c;
    return c;
  endfunction

  function automatic logic [2:0] refWin(logic [7:0] h);
    for (int i = 0; i < 8; i++) if (h[i]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic pix_t mkPix(logic [7:0] hit, logic [7:0] bg, logic [9:0] px,
                                 logic [9:0] py, logic hs, logic vs);
    pix_t p;
    p.hit = hit; p.col = colTab; p.bg = bg; p.x = px; p.y = py; p.hs = hs; p.vs = vs;
    return p;
  endfunction

  function automatic logic [7:0] dutRgb();
    return {bus.vgaRed, bus.vgaGreen, bus.vgaBlue};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOuts();
    chk("rgb",      dutRgb(),                     eRgb);
    chk("win",      8'(bus.win_layer),            8'(eWin));
    chk("hsync",    8'(bus.Hsync),                8'(eHs));
    chk("vsync",    8'(bus.Vsync),                8'(eVs));
    chk("pulse",    8'(bus.collision_pulse),      8'(ePulse));
    chk("collided", 8'(bus.collided),             8'(eCol));
  endtask

  task automatic modelReset();
    mS1 = '0; mVsPrev = 1'b0; mAcc = 0; mCol = 0; mGo = 0;
  endtask

  // One pixel strobe; the model predicts the output of the pixel captured one strobe ago.
  task automatic step(input pix_t p, input logic [1:0] m, input logic clr);
    bit fe, ov, ph;
    @(negedge clk);
    bus.pix_en = 1'b1; bus.x = p.x; bus.y = p.y; bus.hsync_in = p.hs; bus.vsync_in = p.vs;
    bus.layer_hit = p.hit; bus.layer_color = p.col; bus.bg_color = p.bg;
    bus.mode = m; bus.clear_collision = clr;
    fe = mVsPrev && !mS1.vs;
    ov = (mS1.x < 640 && mS1.y < 480) && mS1.hit[0] && (mS1.hit[7:1] != 7'd0);
    ph = (((mGo / FF) % 2) == 1);
    eRgb   = refColor(mS1, m, ph);
    eWin   = refWin(mS1.hit);
    eHs    = mS1.hs;
    eVs    = mS1.vs;
    ePulse = fe && (mAcc || ov);
    mAcc   = fe ? 1'b0 : (mAcc || ov);
    mCol   = ePulse ? 1'b1 : (clr ? 1'b0 : mCol);
    eCol   = mCol;
    mGo    = (m != 2'b10) ? 0 : mGo + (fe ? 1 : 0);
    mVsPrev = mS1.vs;
    mS1     = p;
    @(posedge clk); #1;
    checkOuts();
  endtask

  // Short synthetic frame: four active pixels then two vsync-low blank pixels.
  task automatic runFrame(input fvec_t f, output logic [7:0] mid, output logic pulse,
                          output logic coll);
    for (int s = 0; s < 6; s++) begin
      if (s < 4) step(mkPix(f.hit, f.bg, f.x, f.y, 1'b1, 1'b1), f.mode, f.clr);
      else       step(mkPix(8'h00, f.bg, 10'd700, f.y, (s != 4), 1'b0), f.mode, f.clr);
      if (s == 3) mid = dutRgb();
    end
    pulse = bus.collision_pulse;
    coll  = bus.collided;
  endtask

  pvec_t pv[11];
  fvec_t fv[14];

  initial begin
    logic [7:0] mid;
    logic       pl, cl;
    logic [1:0] rm;
    pix_t       rp;

    colTab = {8'hB5, 8'h27, 8'hE0, 8'h6D, 8'h92, 8'h1C, 8'h41, 8'h03};

    pv[0]  = '{8'h24, 8'h00, 10'd5,   10'd5,   2'b00, 8'h1C, 3'd2};
    pv[1]  = '{8'h00, 8'hFF, 10'd640, 10'd0,   2'b00, 8'h00, 3'd0};
    pv[2]  = '{8'h00, 8'hFF, 10'd639, 10'd479, 2'b00, 8'hFF, 3'd0};
    pv[3]  = '{8'h00, 8'hFF, 10'd639, 10'd479, 2'b01, 8'h00, 3'd0};
    pv[4]  = '{8'h00, 8'hFF, 10'd640, 10'd479, 2'b01, 8'h00, 3'd0};
    pv[5]  = '{8'h24, 8'h00, 10'd5,   10'd5,   2'b01, 8'hE3, 3'd2};
    pv[6]  = '{8'h24, 8'h00, 10'd5,   10'd5,   2'b11, 8'h1C, 3'd2};
    pv[7]  = '{8'h80, 8'h00, 10'd0,   10'd0,   2'b00, 8'hB5, 3'd7};
    pv[8]  = '{8'h01, 8'h00, 10'd0,   10'd0,   2'b00, 8'h03, 3'd0};
    pv[9]  = '{8'h00, 8'hFF, 10'd0,   10'd480, 2'b00, 8'h00, 3'd0};
    pv[10] = '{8'hFE, 8'h00, 10'd300, 10'd300, 2'b00, 8'h41, 3'd1};

    fv[0]  = '{8'h00, 8'hFF, 2'b00, 10'd10,  10'd10,  1'b0, 8'hFF, 1'b0, 1'b0};
    fv[1]  = '{8'h00, 8'hFF, 2'b10, 10'd10,  10'd10,  1'b0, 8'hFF, 1'b0, 1'b0};
    fv[2]  = '{8'h00, 8'hFF, 2'b10, 10'd10,  10'd10,  1'b0, 8'hFF, 1'b0, 1'b0};
    fv[3]  = '{8'h00, 8'hFF, 2'b10, 10'd10,  10'd10,  1'b0, 8'h00, 1'b0, 1'b0};
    fv[4]  = '{8'h00, 8'hFF, 2'b10, 10'd10,  10'd10,  1'b0, 8'h00, 1'b0, 1'b0};
    fv[5]  = '{8'h00, 8'hFF, 2'b10, 10'd10,  10'd10,  1'b0, 8'hFF, 1'b0, 1'b0};
    fv[6]  = '{8'h00, 8'hFF, 2'b10, 10'd10,  10'd10,  1'b0, 8'hFF, 1'b0, 1'b0};
    fv[7]  = '{8'h00, 8'hFF, 2'b00, 10'd10,  10'd10,  1'b0, 8'hFF, 1'b0, 1'b0};
    fv[8]  = '{8'h00, 8'hFF, 2'b10, 10'd10,  10'd10,  1'b0, 8'hFF, 1'b0, 1'b0};
    fv[9]  = '{8'h09, 8'h00, 2'b00, 10'd100, 10'd200, 1'b0, 8'h03, 1'b1, 1'b1};
    fv[10] = '{8'h00, 8'h55, 2'b00, 10'd100, 10'd200, 1'b0, 8'h55, 1'b0, 1'b1};
    fv[11] = '{8'h00, 8'h55, 2'b00, 10'd100, 10'd200, 1'b1, 8'h55, 1'b0, 1'b0};
    fv[12] = '{8'h09, 8'h00, 2'b00, 10'd700, 10'd200, 1'b0, 8'h00, 1'b0, 1'b0};
    fv[13] = '{8'h09, 8'h00, 2'b00, 10'd639, 10'd479, 1'b1, 8'h03, 1'b1, 1'b1};

    // Reset values
    rst = 1'b1;
    bus.pix_en = 1'b0; bus.x = '0; bus.y = '0; bus.hsync_in = 1'b1; bus.vsync_in = 1'b1;
    bus.layer_hit = '0; bus.layer_color = '0; bus.bg_color = '0; bus.mode = 2'b00;
    bus.clear_collision = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb",   dutRgb(),                8'h00);
    chk("rst_hs",    8'(bus.Hsync),           8'h01);
    chk("rst_vs",    8'(bus.Vsync),           8'h01);
    chk("rst_win",   8'(bus.win_layer),       8'h00);
    chk("rst_pulse", 8'(bus.collision_pulse), 8'h00);
    chk("rst_coll",  8'(bus.collided),        8'h00);
    @(negedge clk) rst = 1'b0;

    // Pixel table: hold each vector for two strobes, then compare
    for (int i = 0; i < 11; i++) begin
      repeat (2) step(mkPix(pv[i].hit, pv[i].bg, pv[i].x, pv[i].y, 1'b1, 1'b1), pv[i].mode, 1'b0);
      chk($sformatf("pix%0d_rgb", i), dutRgb(), pv[i].expRgb);
      chk($sformatf("pix%0d_win", i), 8'(bus.win_layer), 8'(pv[i].expWin));
    end

    // Latency: colour and Hsync edge show up exactly two strobes after entry
    step(mkPix(8'h24, 8'h00, 10'd5, 10'd5, 1'b0, 1'b1), 2'b00, 1'b0);
    chk("lat1_rgb", dutRgb(), 8'h41);
    chk("lat1_hs",  8'(bus.Hsync), 8'h01);
    step(mkPix(8'h00, 8'h00, 10'd5, 10'd5, 1'b1, 1'b1), 2'b00, 1'b0);
    chk("lat2_rgb", dutRgb(), 8'h1C);
    chk("lat2_hs",  8'(bus.Hsync), 8'h00);
    step(mkPix(8'h00, 8'h00, 10'd5, 10'd5, 1'b1, 1'b1), 2'b00, 1'b0);
    chk("lat3_rgb", dutRgb(), 8'h00);
    chk("lat3_hs",  8'(bus.Hsync), 8'h01);

    // Frame table: flash sequence, restart, collisions
    for (int i = 0; i < 14; i++) begin
      runFrame(fv[i], mid, pl, cl);
      chk($sformatf("frm%0d_mid", i),   mid,    fv[i].expMid);
      chk($sformatf("frm%0d_pulse", i), 8'(pl), 8'(fv[i].expPulse));
      chk($sformatf("frm%0d_coll", i),  8'(cl), 8'(fv[i].expColl));
    end

    // Asynchronous reset mid-frame while collided is set and syncs are low
    repeat (2) step(mkPix(8'h24, 8'h00, 10'd5, 10'd5, 1'b0, 1'b0), 2'b00, 1'b0);
    #2 rst = 1'b1;
    bus.pix_en = 1'b0;
    #1;
    chk("arst_rgb",  dutRgb(),          8'h00);
    chk("arst_hs",   8'(bus.Hsync),     8'h01);
    chk("arst_vs",   8'(bus.Vsync),     8'h01);
    chk("arst_win",  8'(bus.win_layer), 8'h00);
    chk("arst_coll", 8'(bus.collided),  8'h00);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    modelReset();

    // Randomized scan against the model
    rm = 2'b00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) rm = 2'($urandom_range(0, 3));
      rp.hit = 8'($urandom);
      if ($urandom_range(0, 1) == 1) rp.hit = rp.hit & 8'($urandom);
      for (int j = 0; j < 8; j++) rp.col[j] = 8'($urandom);
      rp.bg = 8'($urandom);
      rp.x  = 10'($urandom_range(0, 700));
      rp.y  = 10'($urandom_range(0, 520));
      rp.hs = ($urandom_range(0, 7) != 0);
      rp.vs = ($urandom_range(0, 5) != 0);
      step(rp, rm, ($urandom_range(0, 15) == 0));
    end

    // pix_en low for 10 clocks: outputs frozen while inputs churn
    step(mkPix(8'h04, 8'h00, 10'd20, 10'd20, 1'b0, 1'b1), rm, 1'b0);
    step(mkPix(8'h02, 8'h00, 10'd21, 10'd20, 1'b1, 1'b1), rm, 1'b0);
    ePulse = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.pix_en = 1'b0; bus.clear_collision = 1'b0;
      bus.x = 10'($urandom); bus.y = 10'($urandom);
      bus.layer_hit = 8'($urandom); bus.layer_color = {$urandom, $urandom};
      bus.bg_color = 8'($urandom); bus.hsync_in = ~bus.hsync_in; bus.vsync_in = ~bus.vsync_in;
      @(posedge clk); #1;
      checkOuts();
    end
    repeat (4) step(mkPix(8'h10, 8'h33, 10'd30, 10'd30, 1'b1, 1'b1), rm, 1'b0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
